race_judge: RTL

Race-progress referee for the two-player racer. Samples both cars' map-space positions every `clk` cycle, tracks ordered checkpoint passage and lap counts per player, keeps the race clock, and decides the finish. Sits downstream of the two physics engines and upstream of the game-state FSM: drives its `is_game_end` input and feeds lap, lead and timer values to the HUD renderer.

---
 rtl/race_pkg.sv | 41 ++++
 rtl/race_judge_if.sv | 31 +++
 rtl/lap_tracker.sv | 55 +++++
 rtl/race_judge.sv | 110 +++++++++++
 4 files changed

// File: rtl/race_pkg.sv
// Shared constants for the race referee: game FSM encodings, checkpoint
// rectangles, progress-key geometry and the rectangle hit test.
package race_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SETTING   = 3'd1;
    localparam logic [2:0] ST_COUNTDOWN = 3'd3;
    localparam logic [2:0] ST_RACING    = 3'd4;
    localparam logic [2:0] ST_PAUSE     = 3'd5;
    localparam logic [2:0] ST_FINISH    = 3'd6;

    localparam int MAX_CP = 8;
    localparam int LAP_W  = 2;
    localparam int CP_W   = 3;
    localparam int RANK_W = 4;  // next_cp rank; CP0 ranks as NUM_CP (up to 8)
    localparam int KEY_W  = LAP_W + RANK_W;

    // Unused slots sit at the far map corner, outside the 320x240 play area.
    localparam logic [9:0] CP_X0 [MAX_CP] = '{10'd5,   10'd140, 10'd285, 10'd140,
                                              10'd1023, 10'd1023, 10'd1023, 10'd1023};
    localparam logic [9:0] CP_X1 [MAX_CP] = '{10'd35,  10'd180, 10'd315, 10'd180,
                                              10'd1023, 10'd1023, 10'd1023, 10'd1023};
    localparam logic [9:0] CP_Y0 [MAX_CP] = '{10'd118, 10'd10,  10'd110, 10'd200,
                                              10'd1023, 10'd1023, 10'd1023, 10'd1023};
    localparam logic [9:0] CP_Y1 [MAX_CP] = '{10'd132, 10'd40,  10'd130, 10'd230,
                                              10'd1023, 10'd1023, 10'd1023, 10'd1023};

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2,
        WIN_TIE  = 2'd3
    } winner_e;

    function automatic logic in_cp(input logic [9:0] x, input logic [9:0] y,
                                   input logic [CP_W-1:0] idx);
        return (x >= CP_X0[idx]) && (x <= CP_X1[idx]) &&
               (y >= CP_Y0[idx]) && (y <= CP_Y1[idx]);
    endfunction

endpackage

// File: rtl/race_judge_if.sv
// Bundle between the game side (positions, FSM state) and the race referee
// (progress, lead, timer and finish verdict).
interface race_judge_if;

    logic [2:0]  state;
    logic [9:0]  p1_x;
    logic [9:0]  p1_y;
    logic [9:0]  p2_x;
    logic [9:0]  p2_y;
    logic [1:0]  p1_lap;
    logic [1:0]  p2_lap;
    logic [2:0]  p1_next_cp;
    logic [2:0]  p2_next_cp;
    logic        p1_leading;
    logic [15:0] race_time_cs;
    logic        is_game_end;
    logic [1:0]  winner;

    modport master (
        output state, p1_x, p1_y, p2_x, p2_y,
        input  p1_lap, p2_lap, p1_next_cp, p2_next_cp,
               p1_leading, race_time_cs, is_game_end, winner
    );

    modport slave (
        input  state, p1_x, p1_y, p2_x, p2_y,
        output p1_lap, p2_lap, p1_next_cp, p2_next_cp,
               p1_leading, race_time_cs, is_game_end, winner
    );

endinterface

// File: rtl/lap_tracker.sv
// Per-player checkpoint sequencer: only the expected checkpoint advances
// progress, and passing CP0 closes a lap.
module lap_tracker
    import race_pkg::*;
#(
    parameter int NUM_LAPS = 3,
    parameter int NUM_CP   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    output logic [LAP_W-1:0]  lap,
    output logic [CP_W-1:0]   next_cp,
    output logic [KEY_W-1:0]  key,
    output logic              lap_done
);

    localparam logic [LAP_W-1:0]  LAST_LAP = LAP_W'(NUM_LAPS);
    localparam logic [CP_W-1:0]   LAST_CP  = CP_W'(NUM_CP - 1);
    localparam logic [RANK_W-1:0] CP0_RANK = RANK_W'(NUM_CP);

    logic advance;
    logic at_line;

    assign advance  = enable && in_cp(x, y, next_cp);
    assign at_line  = (next_cp == '0);
    // High only in the cycle whose edge will make lap equal NUM_LAPS.
    assign lap_done = advance && at_line && (lap == LAST_LAP - 2'd1);
    assign key      = {lap, at_line ? CP0_RANK : {1'b0, next_cp}};

    // NOTE: state updates use non-blocking assignments so the judge samples
    // both trackers' pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lap     <= '0;
            next_cp <= CP_W'(1);
        end else if (clear) begin
            lap     <= '0;
            next_cp <= CP_W'(1);
        end else if (advance) begin
            if (at_line) begin
                if (lap != LAST_LAP) lap <= lap + 2'd1;
                next_cp <= CP_W'(1);
            end else if (next_cp == LAST_CP) begin
                next_cp <= '0;
            end else begin
                next_cp <= next_cp + 3'd1;
            end
        end
    end

endmodule

// File: rtl/race_judge.sv
// Race referee: two lap trackers, the lead comparator, the centisecond race
// clock and the finish/winner decision.
module race_judge
    import race_pkg::*;
#(
    parameter int NUM_LAPS = 3,
    parameter int NUM_CP   = 4,
    parameter int CLK_FREQ = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    race_judge_if.slave bus
);

    localparam int PRE_DIV = CLK_FREQ / 100;
    localparam int PRE_W   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);

    logic             clear;
    logic             active;
    logic [KEY_W-1:0] p1_key;
    logic [KEY_W-1:0] p2_key;
    logic             p1_done;
    logic             p2_done;
    logic             leading;
    logic [PRE_W-1:0] prescale;
    logic [15:0]      time_cs;
    logic             game_end;
    winner_e          winner;

    assign clear  = (bus.state == ST_IDLE) || (bus.state == ST_SETTING);
    // Once decided, nothing moves until the game FSM leaves for IDLE/SETTING.
    assign active = (bus.state == ST_RACING) && !game_end;

    lap_tracker #(.NUM_LAPS(NUM_LAPS), .NUM_CP(NUM_CP)) u_p1 (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .enable   (active),
        .x        (bus.p1_x),
        .y        (bus.p1_y),
        .lap      (bus.p1_lap),
        .next_cp  (bus.p1_next_cp),
        .key      (p1_key),
        .lap_done (p1_done)
    );

    lap_tracker #(.NUM_LAPS(NUM_LAPS), .NUM_CP(NUM_CP)) u_p2 (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .enable   (active),
        .x        (bus.p2_x),
        .y        (bus.p2_y),
        .lap      (bus.p2_lap),
        .next_cp  (bus.p2_next_cp),
        .key      (p2_key),
        .lap_done (p2_done)
    );

    // Equal keys leave the lead with whoever got there first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            leading <= 1'b1;
        end else if (clear) begin
            leading <= 1'b1;
        end else if (active) begin
            if (p1_key > p2_key)      leading <= 1'b1;
            else if (p1_key < p2_key) leading <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescale <= '0;
            time_cs  <= '0;
        end else if (clear) begin
            prescale <= '0;
            time_cs  <= '0;
        end else if (active) begin
            if (prescale == PRE_LAST) begin
                prescale <= '0;
                if (time_cs != 16'hFFFF) time_cs <= time_cs + 16'd1;
            end else begin
                prescale <= prescale + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            game_end <= 1'b0;
            winner   <= WIN_NONE;
        end else if (clear) begin
            game_end <= 1'b0;
            winner   <= WIN_NONE;
        end else if (active && (p1_done || p2_done)) begin
            game_end <= 1'b1;
            if (p1_done && p2_done) winner <= WIN_TIE;
            else if (p1_done)       winner <= WIN_P1;
            else                    winner <= WIN_P2;
        end
    end

    assign bus.p1_leading   = leading;
    assign bus.race_time_cs = time_cs;
    assign bus.is_game_end  = game_end;
    assign bus.winner       = winner;

endmodule
